// File: rtl/el_pkg.sv
// Shared definitions for the elastic-link blocks: signalling names, FSM states
// and the one-hot rail encoder.
package el_pkg;

  localparam string ENC_TWO_PHASE  = "TWO_PHASE";
  localparam string ENC_FOUR_PHASE = "FOUR_PHASE";

  localparam int unsigned EL_MAX_RAILS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_STROBE,
    ST_WAIT_ACK,
    ST_RTZ,
    ST_WAIT_REL
  } el_state_e;

  // Callers truncate the result to their own rail count.
  function automatic logic [EL_MAX_RAILS-1:0] onehot(input int unsigned sym,
                                                     input int unsigned rail_num);
    logic [EL_MAX_RAILS-1:0] v;
    v = {{(EL_MAX_RAILS-1){1'b0}}, 1'b1} << sym;
    if (sym >= rail_num) v = '0;
    return v;
  endfunction

endpackage

// File: rtl/el_ack_sync.sv
// Flop-chain synchroniser for an asynchronous handshake input; clears to 0
// on the asynchronous active-low reset.
module el_ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/el_sync_tx.sv
// Synchronous valid/ready to elastic one-hot token transmitter with two- or
// four-phase request signalling toward el_latch.
module el_sync_tx
  import el_pkg::*;
#(
  parameter string       ENC         = ENC_TWO_PHASE,
  parameter int unsigned RAIL_NUM    = 2,
  parameter int unsigned SYM_W       = $clog2(RAIL_NUM),
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [SYM_W-1:0]    s_data,
  output logic                s_ready,
  output logic                lat_o,
  output logic [RAIL_NUM-1:0] out,
  input  logic                ack_i,
  output logic                busy,
  output logic                err,
  output logic                err_sym
);

  localparam bit          TWO_PH = (ENC == ENC_TWO_PHASE);
  localparam int unsigned WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  el_state_e           state_q, state_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic [RAIL_NUM-1:0] out_q, out_d;
  logic                lat_q, lat_d;
  logic                ph_q, ph_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                err_sym_q, err_sym_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [RAIL_NUM-1:0] sym_hot;
  logic                waiting;
  logic                ack_s;

  el_ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_i),
    .q_o (ack_s)
  );

  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    out_d     = out_q;
    lat_d     = lat_q;
    ph_d      = ph_q;
    err_d     = err_q;
    err_sym_d = 1'b0;
    wd_d      = wd_q;
    waiting   = 1'b0;
    sym_hot   = RAIL_NUM'(onehot(32'(sym_q), RAIL_NUM));

    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          if (32'(s_data) < RAIL_NUM) begin
            sym_d   = s_data;
            state_d = ST_DRIVE;
          end else begin
            err_sym_d = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        out_d   = TWO_PH ? (out_q ^ sym_hot) : sym_hot;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (TWO_PH) begin
          lat_d = ~lat_q;
          ph_d  = ~ph_q;
        end else begin
          lat_d = 1'b1;
        end
        wd_d    = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (TWO_PH ? (ack_s == ph_q) : ack_s) begin
          if (TWO_PH) begin
            state_d = ST_IDLE;
          end else begin
            // Return-to-zero is applied on entry so RTZ is the cycle with both low.
            out_d   = '0;
            lat_d   = 1'b0;
            state_d = ST_RTZ;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      ST_RTZ: begin
        wd_d    = '0;
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
        end else begin
          waiting = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog only flags; the handshake keeps waiting for the ack.
    if (waiting && (TIMEOUT != 0)) begin
      if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
      if (wd_q == WD_MAX - 1'b1) err_d = 1'b1;
    end

    s_ready_d = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sym_q     <= '0;
      out_q     <= '0;
      lat_q     <= 1'b0;
      ph_q      <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_sym_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      sym_q     <= sym_d;
      out_q     <= out_d;
      lat_q     <= lat_d;
      ph_q      <= ph_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      err_sym_q <= err_sym_d;
      wd_q      <= wd_d;
    end
  end

  assign s_ready = s_ready_q;
  assign lat_o   = lat_q;
  assign out     = out_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign err_sym = err_sym_q;

endmodule
